// File: rtl/gray_step_monitor.sv
// Receive-side Gray-code monitor: decodes each valid sample, classifies the step
// against the previous sample, tracks lock state and counts illegal steps.
module gray_step_monitor #(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 direction,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 locked
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_SUSPECT  = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0]     STEP_UP   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     STEP_DOWN = {WIDTH{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO  = {ERR_CNT_W{1'b0}};

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic                   bin_valid_q, bin_valid_d;
    logic                   dir_q, dir_d;
    logic                   step_err_q, step_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   locked_q, locked_d;

    logic [WIDTH-1:0]       new_bin_s;
    logic [WIDTH-1:0]       delta_s;
    logic                   is_up_s;
    logic                   is_down_s;
    logic                   is_legal_s;
    logic                   err_s;

    // Step classification against the last accepted sample (bin_q doubles as prev).
    always_comb begin
        new_bin_s  = gray2bin(gray_in);
        delta_s    = new_bin_s - bin_q;
        is_up_s    = (delta_s == STEP_UP);
        is_down_s  = (delta_s == STEP_DOWN);
        is_legal_s = is_up_s || is_down_s || (delta_s == {WIDTH{1'b0}});
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bin_valid_d = 1'b0;
        dir_d       = dir_q;
        err_s       = 1'b0;
        if (valid) begin
            bin_d       = new_bin_s;
            bin_valid_d = 1'b1;
            case (state_q)
                ST_UNLOCKED: begin
                    state_d = ST_LOCKED;
                end
                ST_LOCKED, ST_SUSPECT: begin
                    if (is_legal_s) begin
                        state_d = ST_LOCKED;
                        if (is_up_s) begin
                            dir_d = 1'b1;
                        end else if (is_down_s) begin
                            dir_d = 1'b0;
                        end else begin
                            dir_d = dir_q;
                        end
                    end else begin
                        err_s   = 1'b1;
                        state_d = (state_q == ST_LOCKED) ? ST_SUSPECT : ST_UNLOCKED;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        step_err_d = err_s;
        locked_d   = (state_d == ST_LOCKED) || (state_d == ST_SUSPECT);

        // A clear coinciding with an error leaves exactly that error counted.
        if (err_clr) begin
            err_cnt_d = err_s ? ERR_ONE : ERR_ZERO;
        end else if (err_s) begin
            err_cnt_d = (err_cnt_q == ERR_MAX) ? ERR_MAX : (err_cnt_q + ERR_ONE);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_UNLOCKED;
            bin_q       <= {WIDTH{1'b0}};
            bin_valid_q <= 1'b0;
            dir_q       <= 1'b1;
            step_err_q  <= 1'b0;
            err_cnt_q   <= ERR_ZERO;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            dir_q       <= dir_d;
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = bin_valid_q;
    assign direction = dir_q;
    assign step_err  = step_err_q;
    assign err_count = err_cnt_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed scenarios plus random walks, compared against
// an integer-arithmetic reference model; two instances cover 8-bit and 2-bit counters.
module tb_gray_step_monitor;

    localparam int W    = 3;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic         valid;
    logic [W-1:0] gray_in;
    logic         err_clr;

    logic [W-1:0] bin_a, bin_b;
    logic         bv_a, bv_b, dir_a, dir_b, se_a, se_b, lk_a, lk_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit have_ref, suspect, m_bv, m_se, m_dir;
    int m_bin, m_cnt8, m_cnt2;

    gray_step_monitor #(.WIDTH(W), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .valid(valid), .gray_in(gray_in), .err_clr(err_clr),
        .bin_out(bin_a), .bin_valid(bv_a), .direction(dir_a), .step_err(se_a),
        .err_count(cnt_a), .locked(lk_a)
    );

    gray_step_monitor #(.WIDTH(W), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .valid(valid), .gray_in(gray_in), .err_clr(err_clr),
        .bin_out(bin_b), .bin_valid(bv_b), .direction(dir_b), .step_err(se_b),
        .err_count(cnt_b), .locked(lk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int g2b(input int g);
        int b = 0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b & MASK;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bin_out_a",   int'(bin_a), m_bin);
        chk("bin_valid_a", int'(bv_a),  int'(m_bv));
        chk("direction_a", int'(dir_a), int'(m_dir));
        chk("step_err_a",  int'(se_a),  int'(m_se));
        chk("err_count_a", int'(cnt_a), m_cnt8);
        chk("locked_a",    int'(lk_a),  int'(have_ref));
        chk("bin_out_b",   int'(bin_b), m_bin);
        chk("direction_b", int'(dir_b), int'(m_dir));
        chk("step_err_b",  int'(se_b),  int'(m_se));
        chk("err_count_b", int'(cnt_b), m_cnt2);
        chk("locked_b",    int'(lk_b),  int'(have_ref));
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input bit v, input int g, input bit clr);
        int n, d;
        bit err;
        valid   = v;
        gray_in = g[W-1:0];
        err_clr = clr;
        @(posedge clk);
        #1;
        err  = 1'b0;
        m_bv = 1'b0;
        if (v) begin
            n = g2b(g);
            if (!have_ref) begin
                have_ref = 1'b1;
                suspect  = 1'b0;
            end else begin
                d = (n - m_bin) & MASK;
                if (d == 0 || d == 1 || d == MASK) begin
                    if (d == 1) m_dir = 1'b1;
                    if (d == MASK) m_dir = 1'b0;
                    suspect = 1'b0;
                end else begin
                    err = 1'b1;
                    if (suspect) begin
                        have_ref = 1'b0;
                        suspect  = 1'b0;
                    end else begin
                        suspect = 1'b1;
                    end
                end
            end
            m_bin = n;
            m_bv  = 1'b1;
        end
        m_se = err;
        if (clr) begin
            m_cnt8 = err ? 1 : 0;
            m_cnt2 = err ? 1 : 0;
        end else if (err) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        check_all();
    endtask

    // Reset with busy inputs to show reset dominates.
    task automatic do_reset();
        reset   = 1'b0;
        valid   = 1'b1;
        gray_in = 3'b101;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        have_ref = 1'b0;
        suspect  = 1'b0;
        m_bin    = 0;
        m_bv     = 1'b0;
        m_se     = 1'b0;
        m_dir    = 1'b1;
        m_cnt8   = 0;
        m_cnt2   = 0;
        check_all();
    endtask

    initial begin
        int b, r;
        reset   = 1'b0;
        valid   = 1'b0;
        gray_in = 3'b000;
        err_clr = 1'b0;
        @(posedge clk);
        #1;

        // reference sample after reset
        do_reset();
        step(1'b1, 3, 1'b0);
        chk("t1_bin_out", int'(bin_a), 2);
        chk("t1_locked", int'(lk_a), 1);

        // full up sweep with wrap
        do_reset();
        for (int i = 0; i <= 8; i++) step(1'b1, b2g(i & MASK), 1'b0);
        chk("t2_wrap_bin", int'(bin_a), 0);
        chk("t2_no_err", int'(cnt_a), 0);

        // downward wrap then hold
        do_reset();
        step(1'b1, 0, 1'b0);
        step(1'b1, 4, 1'b0);
        chk("t3_down_dir", int'(dir_a), 0);
        step(1'b1, 4, 1'b0);
        chk("t3_hold_dir", int'(dir_a), 0);

        // illegal step into suspect, recover
        do_reset();
        step(1'b1, 1, 1'b0);
        step(1'b1, 5, 1'b0);
        chk("t4_suspect_lock", int'(lk_a), 1);
        chk("t4_err1", int'(cnt_a), 1);
        step(1'b1, 4, 1'b0);
        chk("t4_recover_dir", int'(dir_a), 1);
        // second illegal step from suspect drops lock
        do_reset();
        step(1'b1, 1, 1'b0);
        step(1'b1, 5, 1'b0);
        step(1'b1, 2, 1'b0);
        chk("t4_unlock", int'(lk_a), 0);
        chk("t4_err2", int'(cnt_a), 2);

        // idle cycles mid-stream, then reset mid-sweep
        do_reset();
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 6, 1'b0);
        step(1'b1, 3, 1'b0);
        do_reset();
        step(1'b1, 6, 1'b0);

        // saturation with relocking, then clear combined with an error
        do_reset();
        step(1'b1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            b = m_bin;
            step(1'b1, b2g((b + 4) & MASK), 1'b0);
            step(1'b1, b2g((b + 5) & MASK), 1'b0);
        end
        chk("t6_sat2", int'(cnt_b), 3);
        chk("t6_cnt8", int'(cnt_a), 5);
        step(1'b1, b2g((m_bin + 3) & MASK), 1'b1);
        chk("t6_clr_err", int'(cnt_a), 1);
        step(1'b0, 0, 1'b1);
        chk("t6_clr_only", int'(cnt_a), 0);

        // random walk, mostly legal steps with occasional jumps, clears and resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 60)      b = (m_bin + 1) & MASK;
                else if (r < 80) b = (m_bin - 1) & MASK;
                else if (r < 88) b = m_bin;
                else             b = $urandom_range(0, MASK);
                step($urandom_range(0, 4) != 0, b2g(b), $urandom_range(0, 19) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
